// File: rtl/mult_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mult_error_monitor
// Purpose  : Exhaustive stimulus driver and result checker for an (approximate)
//            multiplier. Sweeps every operand pair (in2 inner loop), compares
//            {overflow,out} against the exact unsigned product and accumulates
//            error statistics: mismatch count, max / summed error distance and
//            the first failing operand pair.
// Ports    : clk, rst (async, active-high)
//            start            - begin a sweep (accepted in IDLE or DONE only)
//            busy / done      - sweep in progress / sweep complete (held)
//            in1, in2         - operands driven to the multiplier
//            out, overflow    - product low / high halves from the multiplier
//            err_count        - number of mismatching pairs
//            max_err          - largest |result - exact|
//            err_sum          - sum of |result - exact|
//            first_fail_*     - valid flag and operands of the first mismatch
// Revision : 1.0 - initial release
// ============================================================================
module mult_error_monitor #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     in1,
  output logic [WIDTH-1:0]     in2,
  input  logic [WIDTH-1:0]     out,
  input  logic [WIDTH-1:0]     overflow,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   max_err,
  output logic [4*WIDTH-1:0]   err_sum,
  output logic                 first_fail_valid,
  output logic [WIDTH-1:0]     first_fail_in1,
  output logic [WIDTH-1:0]     first_fail_in2
);

  localparam int                CW            = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     C_SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0]  C_OP_MAX      = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_settle_cnt;

  logic [2*WIDTH-1:0] w_res;
  logic [2*WIDTH-1:0] w_exact;
  logic [2*WIDTH-1:0] w_diff;
  logic               w_err;
  logic               w_last_pair;
  logic               w_start_ok;

  assign w_res       = {overflow, out};
  assign w_exact     = (2*WIDTH)'(in1) * (2*WIDTH)'(in2);
  // Absolute distance without needing a signed intermediate.
  assign w_diff      = (w_res >= w_exact) ? (w_res - w_exact) : (w_exact - w_res);
  assign w_err       = (w_diff != '0);
  assign w_last_pair = (in1 == C_OP_MAX) && (in2 == C_OP_MAX);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_settle_cnt     <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      in1              <= '0;
      in2              <= '0;
      err_count        <= '0;
      max_err          <= '0;
      err_sum          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_in1   <= '0;
      first_fail_in2   <= '0;
    end else begin
      if (w_start_ok) begin
        // Fresh sweep: clear statistics and restart from pair (0,0).
        r_state          <= S_DRIVE;
        r_settle_cnt     <= '0;
        busy             <= 1'b1;
        done             <= 1'b0;
        in1              <= '0;
        in2              <= '0;
        err_count        <= '0;
        max_err          <= '0;
        err_sum          <= '0;
        first_fail_valid <= 1'b0;
        first_fail_in1   <= '0;
        first_fail_in2   <= '0;
      end else begin
        case (r_state)
          S_DRIVE: begin
            // Hold operands for SETTLE cycles so the multiplier output settles.
            if (r_settle_cnt == C_SETTLE_LAST) begin
              r_state      <= S_SAMPLE;
              r_settle_cnt <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + CW'(1);
            end
          end

          S_SAMPLE: begin
            if (w_err) begin
              err_count <= err_count + (2*WIDTH+1)'(1);
              err_sum   <= err_sum + (4*WIDTH)'(w_diff);
              if (w_diff > max_err) begin
                max_err <= w_diff;
              end
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_in1   <= in1;
                first_fail_in2   <= in2;
              end
            end

            if (w_last_pair) begin
              // Operands remain on the final pair while in DONE.
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= S_DRIVE;
              in2     <= in2 + WIDTH'(1);
              if (in2 == C_OP_MAX) begin
                in1 <= in1 + WIDTH'(1);
              end
            end
          end

          S_IDLE: begin
            busy <= 1'b0;
            done <= 1'b0;
          end

          S_DONE: begin
            busy <= 1'b0;
            done <= 1'b1;
          end

          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_error_monitor
// Purpose  : Directed self-checking bench for mult_error_monitor. Two
//            instances (WIDTH=4 with SETTLE=1 and SETTLE=3) are driven by a
//            behavioural multiplier whose behaviour is selectable: exact,
//            forced-zero, or exact XOR 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_error_monitor;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural multiplier: 0 = exact, 1 = forced zero, 2 = exact XOR 1
  int mode_a = 0;
  int mode_b = 0;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input int           m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (m)
      1:       p = '0;
      2:       p = p ^ {{(2*W-1){1'b0}}, 1'b1};
      default: ;
    endcase
    return p;
  endfunction

  // ---------------- DUT A : SETTLE = 1 ----------------
  logic           start_a = 1'b0;
  logic           busy_a, done_a, ffv_a;
  logic [W-1:0]   in1_a, in2_a, out_a, ovf_a, ff1_a, ff2_a;
  logic [2*W:0]   ec_a;
  logic [2*W-1:0] me_a;
  logic [4*W-1:0] es_a;

  assign {ovf_a, out_a} = model(in1_a, in2_a, mode_a);

  mult_error_monitor #(.WIDTH(W), .SETTLE(1)) u_dut_a (
    .clk              (clk),
    .rst              (rst),
    .start            (start_a),
    .busy             (busy_a),
    .done             (done_a),
    .in1              (in1_a),
    .in2              (in2_a),
    .out              (out_a),
    .overflow         (ovf_a),
    .err_count        (ec_a),
    .max_err          (me_a),
    .err_sum          (es_a),
    .first_fail_valid (ffv_a),
    .first_fail_in1   (ff1_a),
    .first_fail_in2   (ff2_a)
  );

  // ---------------- DUT B : SETTLE = 3 ----------------
  logic           start_b = 1'b0;
  logic           busy_b, done_b, ffv_b;
  logic [W-1:0]   in1_b, in2_b, out_b, ovf_b, ff1_b, ff2_b;
  logic [2*W:0]   ec_b;
  logic [2*W-1:0] me_b;
  logic [4*W-1:0] es_b;

  assign {ovf_b, out_b} = model(in1_b, in2_b, mode_b);

  mult_error_monitor #(.WIDTH(W), .SETTLE(3)) u_dut_b (
    .clk              (clk),
    .rst              (rst),
    .start            (start_b),
    .busy             (busy_b),
    .done             (done_b),
    .in1              (in1_b),
    .in2              (in2_b),
    .out              (out_b),
    .overflow         (ovf_b),
    .err_count        (ec_b),
    .max_err          (me_b),
    .err_sum          (es_b),
    .first_fail_valid (ffv_b),
    .first_fail_in1   (ff1_b),
    .first_fail_in2   (ff2_b)
  );

  // Operand hold-time monitor for DUT B: every pair must be held 4 cycles.
  int b_runlen  = 0;
  int b_viol    = 0;
  int b_changes = 0;
  bit b_seen    = 1'b0;
  logic [2*W-1:0] b_prev = '0;

  always @(negedge clk) begin
    if (!busy_b) begin
      b_seen   = 1'b0;
      b_runlen = 0;
      b_prev   = {in1_b, in2_b};
    end else if ({in1_b, in2_b} == b_prev) begin
      b_runlen = b_runlen + 1;
    end else begin
      if (b_seen && b_runlen != 4) b_viol = b_viol + 1;
      b_seen    = 1'b1;
      b_runlen  = 1;
      b_changes = b_changes + 1;
      b_prev    = {in1_b, in2_b};
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen (bounded).
  task automatic wait_done_a(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done_a && cyc < 3000);
  endtask

  task automatic check_stats_a(input string tag, input int ec, input int me,
                               input int es, input bit ffv, input int f1,
                               input int f2);
    check_eq({tag, " err_count"}, 64'(ec_a), 64'(ec));
    check_eq({tag, " max_err"},   64'(me_a), 64'(me));
    check_eq({tag, " err_sum"},   64'(es_a), 64'(es));
    check_eq({tag, " ff_valid"},  64'(ffv_a), 64'(ffv));
    check_eq({tag, " ff_in1"},    64'(ff1_a), 64'(f1));
    check_eq({tag, " ff_in2"},    64'(ff2_a), 64'(f2));
  endtask

  initial begin
    int cyc;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst busy", 64'(busy_a), 0);
    check_eq("rst done", 64'(done_a), 0);
    check_eq("rst in1",  64'(in1_a),  0);
    check_eq("rst in2",  64'(in2_a),  0);
    check_stats_a("rst", 0, 0, 0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- exact multiplier ----------------
    mode_a = 0;
    pulse_start_a();
    check_eq("exact busy after accept", 64'(busy_a), 1);
    wait_done_a(cyc);
    check_eq("exact done latency", 64'(cyc), 512);
    check_eq("exact busy at done", 64'(busy_a), 0);
    check_eq("exact last in1", 64'(in1_a), 15);
    check_eq("exact last in2", 64'(in2_a), 15);
    check_stats_a("exact", 0, 0, 0, 1'b0, 0, 0);

    // ---------------- forced-zero multiplier ----------------
    mode_a = 1;
    pulse_start_a();
    check_eq("zero done dropped", 64'(done_a), 0);
    wait_done_a(cyc);
    check_eq("zero done latency", 64'(cyc), 512);
    check_stats_a("zero", 225, 225, 14400, 1'b1, 1, 1);

    // ---------------- exact XOR 1 ----------------
    mode_a = 2;
    pulse_start_a();
    wait_done_a(cyc);
    check_eq("xor done latency", 64'(cyc), 512);
    check_stats_a("xor", 256, 1, 256, 1'b1, 0, 0);

    // ---------------- restart after errors with exact model ----------------
    repeat (10) @(posedge clk);
    #1;
    check_eq("done held", 64'(done_a), 1);
    check_eq("stats stable in done", 64'(ec_a), 256);
    mode_a = 0;
    pulse_start_a();
    check_eq("restart done dropped", 64'(done_a), 0);
    check_stats_a("restart cleared", 0, 0, 0, 1'b0, 0, 0);
    wait_done_a(cyc);
    check_eq("restart done latency", 64'(cyc), 512);
    check_eq("restart err_count", 64'(ec_a), 0);

    // ---------------- SETTLE=3, mid-sweep start ignored ----------------
    mode_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      start_b = (cyc == 300);
    end while (!done_b && cyc < 5000);
    start_b = 1'b0;
    check_eq("settle3 done latency", 64'(cyc), 1024);
    check_eq("settle3 hold violations", 64'(b_viol), 0);
    check_eq("settle3 operand changes", 64'(b_changes), 255);
    check_eq("settle3 err_count", 64'(ec_b), 0);
    check_eq("settle3 ff_valid", 64'(ffv_b), 0);

    // ---------------- async reset mid-sweep ----------------
    mode_a = 1;
    pulse_start_a();
    repeat (100) @(posedge clk);
    #1;
    check_eq("pre-reset err_count", 64'(ec_a), 31);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async rst busy", 64'(busy_a), 0);
    check_eq("async rst done", 64'(done_a), 0);
    check_eq("async rst in1", 64'(in1_a), 0);
    check_eq("async rst in2", 64'(in2_a), 0);
    check_stats_a("async rst", 0, 0, 0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle no done", 64'(done_a), 0);
    mode_a = 0;
    pulse_start_a();
    wait_done_a(cyc);
    check_eq("post-reset done latency", 64'(cyc), 512);
    check_stats_a("post-reset", 0, 0, 0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_error_monitor.md
Name: mult_error_monitor

Overview:
- Synthesizable initiator/checker for the tb side of if_multiplier: drives in1/in2 and samples {overflow,out} from the multiplier side.
- Exhaustively sweeps all operand pairs and compares each sampled result against the exact product.
- Accumulates error statistics (error count, max error, error-distance sum, first failing pair) for characterising approximate dadda multipliers on-chip or in sim.

Parameters:
- WIDTH, 6, operand width; product is 2*WIDTH bits ({overflow,out}).
- SETTLE, 1, cycles operands are held before sampling (>=1); covers combinational multiplier delay.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin sweep; accepted only in IDLE or DONE
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until next accepted start
- in1  output  WIDTH  operand A to multiplier
- in2  output  WIDTH  operand B to multiplier
- out  input  WIDTH  product low half from multiplier
- overflow  input  WIDTH  product high half from multiplier
- err_count  output  2*WIDTH+1  number of pairs with result != exact
- max_err  output  2*WIDTH  largest |result - exact|
- err_sum  output  4*WIDTH  sum of |result - exact| over all pairs
- first_fail_valid  output  1  at least one mismatch seen
- first_fail_in1  output  WIDTH  in1 of first mismatch
- first_fail_in2  output  WIDTH  in2 of first mismatch

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0.
- States:
  - IDLE: busy=0, done=0. start -> DRIVE.
  - DRIVE: busy=1. Operands held stable for exactly SETTLE cycles, then -> SAMPLE.
  - SAMPLE: busy=1, one cycle.
  - DONE: busy=0, done=1. start -> DRIVE.
- Accepted start (IDLE/DONE):
  - Clears err_count, max_err, err_sum, first_fail_*.
  - Sets in1=0, in2=0; done drops the next cycle.
- SAMPLE cycle:
  - res={overflow,out}; exact=in1*in2 at full 2*WIDTH width, unsigned; diff=|res-exact|.
  - If diff!=0: err_count+=1; err_sum+=diff; max_err=max(max_err,diff).
  - If diff!=0 and first_fail_valid=0: capture in1/in2 into first_fail_*, set first_fail_valid.
- Sweep order: in2 is the inner loop.
  - After SAMPLE: in2 increments; on in2 wrap to 0, in1 increments.
  - In the SAMPLE of pair (2^WIDTH-1, 2^WIDTH-1): -> DONE, operands stay at that last pair; otherwise -> DRIVE.
- Timing: each pair takes SETTLE+1 cycles. done rises 2^(2*WIDTH)*(SETTLE+1) cycles after the start-accept edge (8192 at defaults).
- start while busy: ignored; the sweep is unaffected.
- Stats update only in SAMPLE, are stable in DONE, and are readable mid-sweep (partial).
- Widths are sized so no counter can overflow; no saturation logic.
- Reset mid-sweep: immediate return to IDLE, stats cleared, no done pulse.

Test Plan (bench overrides WIDTH=4, SETTLE=1 unless noted):
- Exact behavioural multiplier, start pulse -> done rises exactly 512 cycles after accept; err_count=0, max_err=0, err_sum=0, first_fail_valid=0.
- Model result forced to 0 -> err_count=225, max_err=225, err_sum=14400, first_fail=(1,1).
- Model returns exact XOR 1 -> err_count=256, max_err=1, err_sum=256, first_fail=(0,0).
- Exact model with SETTLE=3 -> done after 1024 cycles; operands stable 3 cycles before each sample; start pulsed mid-sweep changes nothing.
- Assert rst at cycle 100 of a sweep -> all outputs 0 asynchronously, state IDLE; a new start runs a full clean sweep.
- After DONE with errors, swap in the exact model and start again -> stats cleared on accept, final err_count=0; done held high until that start.
